// File: rtl/p2_writeback_arbiter.sv
// ============================================================================
// Module   : p2_writeback_arbiter
// Purpose  : Shares PRF write port p2 and the completion port between the
//            load, complex and CSR units through private 2-entry buffers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module p2_writeback_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic        flush_i,

    input  logic        ld_vld_i,
    input  logic [5:0]  ld_dest_i,
    input  logic [31:0] ld_data_i,
    input  logic [5:0]  ld_rob_i,
    output logic        ld_ready_o,

    input  logic        cu_vld_i,
    input  logic [5:0]  cu_dest_i,
    input  logic [31:0] cu_data_i,
    input  logic [5:0]  cu_rob_i,
    output logic        cu_ready_o,

    input  logic        csr_vld_i,
    input  logic [5:0]  csr_dest_i,
    input  logic [31:0] csr_data_i,
    input  logic [5:0]  csr_rob_i,
    input  logic        csr_excp_i,
    output logic        csr_ready_o,

    output logic        p2_we_o,
    output logic [5:0]  p2_we_dest_o,
    output logic [31:0] p2_we_data_o,
    output logic        completion_valid_o,
    output logic [5:0]  completed_rob_o,
    output logic        exception_o,
    output logic [5:0]  exception_rob_o,
    output logic [3:0]  exception_code_o
);

    localparam int       c_NSRC  = 3;
    localparam int       c_EW    = 45;
    localparam logic [2:0] c_LIMIT = 3'(STARVE_LIMIT);

    // Entry layout: {excp, dest[5:0], data[31:0], rob[5:0]}
    logic [c_NSRC-1:0][c_EW-1:0] w_push_entry;
    logic [c_NSRC-1:0][c_EW-1:0] w_head;
    logic [c_NSRC-1:0]           w_vld;
    logic [c_NSRC-1:0]           w_ready;
    logic [c_NSRC-1:0]           w_push;
    logic [c_NSRC-1:0]           w_nonempty;
    logic [c_NSRC-1:0]           w_grant;
    logic                        w_clear;

    logic                        w_nl_pend;
    logic                        w_nl_cu;
    logic                        w_starved;
    logic [c_EW-1:0]             w_gnt_entry;

    logic [2:0]                  r_starve_cnt;
    logic                        r_rr_ptr;

    assign w_clear = cpu_rst_i | flush_i;

    assign w_push_entry[0] = {1'b0,       ld_dest_i,  ld_data_i,  ld_rob_i};
    assign w_push_entry[1] = {1'b0,       cu_dest_i,  cu_data_i,  cu_rob_i};
    assign w_push_entry[2] = {csr_excp_i, csr_dest_i, csr_data_i, csr_rob_i};
    assign w_vld           = {csr_vld_i, cu_vld_i, ld_vld_i};
    assign w_push          = w_vld & w_ready;

    assign ld_ready_o  = w_ready[0];
    assign cu_ready_o  = w_ready[1];
    assign csr_ready_o = w_ready[2];

    generate
        for (genvar gi = 0; gi < c_NSRC; gi++) begin : g_fifo
            logic [c_EW-1:0] r_mem [2];
            logic [1:0]      r_count;
            logic            r_wptr;
            logic            r_rptr;

            assign w_ready[gi]    = (r_count < 2'd2);
            assign w_nonempty[gi] = (r_count != 2'd0);
            assign w_head[gi]     = r_mem[r_rptr];

            always_ff @(posedge cpu_clk_i) begin
                if (w_clear) begin
                    r_count <= 2'd0;
                    r_wptr  <= 1'b0;
                    r_rptr  <= 1'b0;
                end else begin
                    if (w_push[gi]) begin
                        r_mem[r_wptr] <= w_push_entry[gi];
                        r_wptr        <= ~r_wptr;
                    end
                    if (w_grant[gi]) begin
                        r_rptr <= ~r_rptr;
                    end
                    r_count <= r_count + {1'b0, w_push[gi]} - {1'b0, w_grant[gi]};
                end
            end
        end
    endgenerate

    // Loads win unless a non-load result has watched STARVE_LIMIT load grants go by.
    always_comb begin
        w_grant   = '0;
        w_nl_pend = w_nonempty[1] | w_nonempty[2];
        if (w_nonempty[1] && w_nonempty[2]) begin
            w_nl_cu = ~r_rr_ptr;
        end else begin
            w_nl_cu = w_nonempty[1];
        end
        w_starved = w_nl_pend && (r_starve_cnt == c_LIMIT);
        if (w_nonempty[0] && !w_starved) begin
            w_grant = 3'b001;
        end else if (w_nl_pend) begin
            w_grant = w_nl_cu ? 3'b010 : 3'b100;
        end
    end

    always_comb begin
        w_gnt_entry = w_head[2];
        if (w_grant[0]) begin
            w_gnt_entry = w_head[0];
        end else if (w_grant[1]) begin
            w_gnt_entry = w_head[1];
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (w_clear) begin
            p2_we_o            <= 1'b0;
            p2_we_dest_o       <= 6'd0;
            p2_we_data_o       <= 32'd0;
            completion_valid_o <= 1'b0;
            completed_rob_o    <= 6'd0;
            exception_o        <= 1'b0;
            exception_rob_o    <= 6'd0;
            r_starve_cnt       <= 3'd0;
            r_rr_ptr           <= 1'b0;
        end else begin
            p2_we_o            <= 1'b0;
            completion_valid_o <= 1'b0;
            exception_o        <= 1'b0;
            if (|w_grant) begin
                p2_we_dest_o    <= w_gnt_entry[43:38];
                p2_we_data_o    <= w_gnt_entry[37:6];
                completed_rob_o <= w_gnt_entry[5:0];
                if (w_gnt_entry[44]) begin
                    exception_o     <= 1'b1;
                    exception_rob_o <= w_gnt_entry[5:0];
                end else begin
                    completion_valid_o <= 1'b1;
                    p2_we_o            <= (w_gnt_entry[43:38] != 6'd0);
                end
            end
            if (w_grant[1] || w_grant[2]) begin
                r_starve_cnt <= 3'd0;
                r_rr_ptr     <= w_grant[1];
            end else if (w_grant[0] && w_nl_pend) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end

    assign exception_code_o = 4'd2;

endmodule

`default_nettype wire
